// File: rtl/alu_pkg.sv
// Shared ALU decode constants and the base funct3 -> op table.
package alu_pkg;
  localparam int CTRL_W_DEF = 5;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SLT    = 5'd5;
  localparam logic [4:0] ALU_SLL    = 5'd6;
  localparam logic [4:0] ALU_SLTU   = 5'd7;
  localparam logic [4:0] ALU_SRL    = 5'd8;
  localparam logic [4:0] ALU_SRA    = 5'd9;
  localparam logic [4:0] ALU_PASSB  = 5'd15;
  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  localparam logic [1:0] AOP_LS    = 2'b00;
  localparam logic [1:0] AOP_BR    = 2'b01;
  localparam logic [1:0] AOP_ARITH = 2'b10;
  localparam logic [1:0] AOP_LUI   = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // funct3 decode for the funct7=0000000 row (shared by R and most I forms)
  function automatic logic [4:0] base_code(input logic [2:0] f3);
    case (f3)
      3'b000:  base_code = ALU_ADD;
      3'b001:  base_code = ALU_SLL;
      3'b010:  base_code = ALU_SLT;
      3'b011:  base_code = ALU_SLTU;
      3'b100:  base_code = ALU_XOR;
      3'b101:  base_code = ALU_SRL;
      3'b110:  base_code = ALU_OR;
      default: base_code = ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational ALU control decode; illegal encodings fall back to ADD.
module alu_decode_comb
  import alu_pkg::*;
#(
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int ENABLE_M = 0
) (
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              op5,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal
);
  logic [4:0] code;
  logic       ill;

  // decode table; illegal forces the code back to ADD at the end
  always_comb begin
    code = ALU_ADD;
    ill  = 1'b0;
    case (alu_op)
      AOP_LS:  code = ALU_ADD;
      AOP_BR:  code = ALU_SUB;
      AOP_LUI: code = ALU_PASSB;
      default: begin
        if (op5) begin
          if (funct7 == F7_BASE)
            code = base_code(funct3);
          else if (funct7 == F7_ALT) begin
            if (funct3 == 3'b000)      code = ALU_SUB;
            else if (funct3 == 3'b101) code = ALU_SRA;
            else                       ill  = 1'b1;
          end else if (funct7 == F7_MULDIV && ENABLE_M != 0)
            code = {2'b10, funct3};
          else
            ill = 1'b1;
        end else begin
          case (funct3)
            3'b001: if (funct7 == F7_BASE) code = ALU_SLL; else ill = 1'b1;
            3'b101: begin
              if (funct7 == F7_BASE)     code = ALU_SRL;
              else if (funct7 == F7_ALT) code = ALU_SRA;
              else                       ill  = 1'b1;
            end
            default: code = base_code(funct3);
          endcase
        end
      end
    endcase
    if (ill) code = ALU_ADD;
  end

  assign alu_ctrl = CTRL_W'(code);
  assign illegal  = ill;
endmodule

// File: rtl/alu_decode_stage.sv
// Registered ALU decode stage: comb decode feeding a 2-entry in-order skid
// buffer with flush, plus a saturating count of illegal deliveries.
module alu_decode_stage
  import alu_pkg::*;
#(
  parameter int CTRL_W   = CTRL_W_DEF,
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic              op5,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              illegal,
  output logic [CNT_W-1:0]  ill_count
);
  logic [CTRL_W-1:0] d_ctrl;
  logic              d_ill;
  logic [CTRL_W:0]   din, e0, e1; // {ctrl, illegal}; e0 is the head
  logic [1:0]        cnt;
  logic              acc, deq;

  alu_decode_comb #(.CTRL_W(CTRL_W), .ENABLE_M(ENABLE_M)) u_dec (
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .op5(op5),
    .alu_ctrl(d_ctrl), .illegal(d_ill)
  );

  assign din       = {d_ctrl, d_ill};
  assign in_ready  = (cnt != 2'd2) && !rst;
  assign out_valid = (cnt != 2'd0);
  assign alu_ctrl  = e0[CTRL_W:1];
  assign illegal   = e0[0];
  assign acc       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  // FIFO occupancy and entry movement; flush drops contents and any accept
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({acc, deq})
        2'b10: begin
          if (cnt == 2'd0) e0 <= din;
          else             e1 <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // head leaves while a new entry arrives: count stays put
          if (cnt == 2'd1) e0 <= din;
          else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  // saturating illegal counter, bumped by every delivery (flush included)
  always_ff @(posedge clk) begin
    if (rst)
      ill_count <= '0;
    else if (deq && e0[0] && !(&ill_count))
      ill_count <= ill_count + 1'b1;
  end
endmodule
